// File: rtl/nibbler_pkg.sv
// Shared opcode encodings, phase encoding and ALU operation set for the Nibbler core.
package nibbler_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LIT   = 4'h1;
  localparam logic [3:0] OP_ADDI  = 4'h2;
  localparam logic [3:0] OP_NANDI = 4'h3;
  localparam logic [3:0] OP_CMPI  = 4'h4;
  localparam logic [3:0] OP_LD    = 4'h5;
  localparam logic [3:0] OP_ST    = 4'h6;
  localparam logic [3:0] OP_ADDM  = 4'h7;
  localparam logic [3:0] OP_IN    = 4'h8;
  localparam logic [3:0] OP_OUT   = 4'h9;
  localparam logic [3:0] OP_JMP   = 4'hA;
  localparam logic [3:0] OP_JC    = 4'hB;
  localparam logic [3:0] OP_JNC   = 4'hC;
  localparam logic [3:0] OP_JZ    = 4'hD;
  localparam logic [3:0] OP_JNZ   = 4'hE;
  localparam logic [3:0] OP_HALT  = 4'hF;

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } phase_t;

  typedef enum logic [1:0] {
    ALU_ADD,
    ALU_NAND,
    ALU_CMP,
    ALU_PASS
  } alu_op_t;

  // Branch condition uses the flags as they stand when the jump executes.
  function automatic logic branch_taken(input logic [3:0] op, input logic c, input logic z);
    logic taken;
    taken = 1'b0;
    case (op)
      OP_JMP:  taken = 1'b1;
      OP_JC:   taken = c;
      OP_JNC:  taken = ~c;
      OP_JZ:   taken = z;
      OP_JNZ:  taken = ~z;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/nibbler_if.sv
// Program-memory fetch and data-RAM bus between the Nibbler core and its memories.
interface nibbler_if #(
  parameter int W  = 4,
  parameter int PW = 12,
  parameter int AW = 12
);

  logic [PW+3:0] instr_word;
  logic          instr_valid;
  logic [PW-1:0] pc;
  logic [AW-1:0] ram_addr;
  logic [W-1:0]  ram_wdata;
  logic [W-1:0]  ram_rdata;
  logic          ram_we;

  modport master (
    input  instr_word, instr_valid, ram_rdata,
    output pc, ram_addr, ram_wdata, ram_we
  );

  modport slave (
    output instr_word, instr_valid, ram_rdata,
    input  pc, ram_addr, ram_wdata, ram_we
  );

endinterface

// File: rtl/nibbler_alu.sv
// Combinational W-bit ALU: add, nand, compare (a - b with borrow-free carry) and pass-through of b.
module nibbler_alu
  import nibbler_pkg::*;
#(
  parameter int W = 4
) (
  input  alu_op_t      op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] result,
  output logic         carry,
  output logic         zero
);

  logic [W:0] sum;
  logic [W:0] diff;

  // Compare is a two's-complement subtract, so carry means a >= b unsigned.
  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    diff   = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
    result = '0;
    carry  = 1'b0;
    case (op)
      ALU_ADD:  {carry, result} = sum;
      ALU_NAND: result = ~(a & b);
      ALU_CMP:  {carry, result} = diff;
      default:  result = b;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/nibbler_core.sv
// Two-phase fetch/execute accumulator core: PC, IR, phase FSM, flags, accumulator,
// output register and branch decode around the nibbler_alu datapath.
module nibbler_core
  import nibbler_pkg::*;
#(
  parameter int W  = 4,
  parameter int PW = 12,
  parameter int AW = 12
) (
  input  logic         clock,
  input  logic         reset,
  nibbler_if.master    bus,
  output logic         phase,
  input  logic [W-1:0] pushbuttons,
  output logic [W-1:0] ff_out,
  output logic [W-1:0] accu,
  output logic         c_flag,
  output logic         z_flag,
  output logic         halted
);

  phase_t        state;
  logic [3:0]    ir_op;
  logic [PW-1:0] ir_operand;
  logic [PW-1:0] pc_q;

  alu_op_t       alu_op;
  logic [W-1:0]  alu_b;
  logic [W-1:0]  alu_result;
  logic          alu_carry;
  logic          alu_zero;

  nibbler_alu #(.W(W)) u_alu (
    .op     (alu_op),
    .a      (accu),
    .b      (alu_b),
    .result (alu_result),
    .carry  (alu_carry),
    .zero   (alu_zero)
  );

  always_comb begin
    alu_op = ALU_PASS;
    alu_b  = ir_operand[W-1:0];
    case (ir_op)
      OP_ADDI:  alu_op = ALU_ADD;
      OP_NANDI: alu_op = ALU_NAND;
      OP_CMPI:  alu_op = ALU_CMP;
      OP_LD:    alu_b  = bus.ram_rdata;
      OP_ADDM: begin
        alu_op = ALU_ADD;
        alu_b  = bus.ram_rdata;
      end
      OP_IN:    alu_b  = pushbuttons;
      default:  alu_op = ALU_PASS;
    endcase
  end

  // Write strobe is decoded from the registered IR so an async reset kills it at once.
  assign bus.ram_we    = (state == EXEC) && (ir_op == OP_ST);
  assign bus.ram_addr  = ir_operand[AW-1:0];
  assign bus.ram_wdata = accu;
  assign bus.pc        = pc_q;
  assign phase         = (state == EXEC);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= FETCH;
      ir_op      <= OP_NOP;
      ir_operand <= '0;
      pc_q       <= '0;
      accu       <= '0;
      ff_out     <= '0;
      c_flag     <= 1'b0;
      z_flag     <= 1'b0;
      halted     <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (bus.instr_valid && !halted) begin
            ir_op      <= bus.instr_word[PW+3:PW];
            ir_operand <= bus.instr_word[PW-1:0];
            state      <= EXEC;
          end
        end
        EXEC: begin
          state <= FETCH;
          if (branch_taken(ir_op, c_flag, z_flag)) begin
            pc_q <= ir_operand;
          end else if (ir_op != OP_HALT) begin
            pc_q <= pc_q + PW'(1);
          end
          case (ir_op)
            OP_LIT, OP_LD, OP_IN: begin
              accu   <= alu_result;
              z_flag <= alu_zero;
            end
            OP_ADDI, OP_ADDM: begin
              accu   <= alu_result;
              c_flag <= alu_carry;
              z_flag <= alu_zero;
            end
            OP_NANDI: begin
              accu   <= alu_result;
              z_flag <= alu_zero;
            end
            OP_CMPI: begin
              c_flag <= alu_carry;
              z_flag <= alu_zero;
            end
            OP_OUT:  ff_out <= accu;
            OP_HALT: halted <= 1'b1;
            default: ;
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibbler_core.sv
// Scoreboard bench for nibbler_core: directed programs plus random instructions checked
// against an arithmetic reference model of the instruction set.
module tb_nibbler_core;
  import nibbler_pkg::*;

  localparam int W         = 4;
  localparam int PW        = 12;
  localparam int AW        = 12;
  localparam int MASK      = (1 << W) - 1;
  localparam int PC_SPAN   = 1 << PW;
  localparam int RAM_DEPTH = 1 << AW;

  typedef struct {
    int pc;
    int accu;
    int c;
    int z;
    int ff_out;
    int halted;
  } exp_t;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  logic         clock;
  logic         reset;
  logic         phase;
  logic [W-1:0] pushbuttons;
  logic [W-1:0] ff_out;
  logic [W-1:0] accu;
  logic         c_flag;
  logic         z_flag;
  logic         halted;

  int checks;
  int errors;

  exp_t exp_q[$];
  wr_t  wr_q[$];

  int m_pc, m_acc, m_c, m_z, m_out, m_halt;
  int m_ram [RAM_DEPTH];
  int init_mem [RAM_DEPTH];

  logic [W-1:0] env_mem [RAM_DEPTH];
  bit           env_written [RAM_DEPTH];
  logic         prev_phase;

  nibbler_if #(.W(W), .PW(PW), .AW(AW)) bus ();

  nibbler_core #(.W(W), .PW(PW), .AW(AW)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .phase       (phase),
    .pushbuttons (pushbuttons),
    .ff_out      (ff_out),
    .accu        (accu),
    .c_flag      (c_flag),
    .z_flag      (z_flag),
    .halted      (halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Environment RAM with asynchronous read; unwritten words come from the random image.
  always @(posedge clock) begin
    if (bus.ram_we) begin
      env_mem[bus.ram_addr]     <= bus.ram_wdata;
      env_written[bus.ram_addr] <= 1'b1;
    end
  end

  assign bus.ram_rdata = env_written[bus.ram_addr] ? env_mem[bus.ram_addr]
                                                   : init_mem[bus.ram_addr][W-1:0];

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    m_pc   = 0;
    m_acc  = 0;
    m_c    = 0;
    m_z    = 0;
    m_out  = 0;
    m_halt = 0;
  endtask

  // Reference model: one instruction's architectural effect, expressed with plain integers.
  task automatic model_exec(input int op, input int opnd, input int pb);
    int   imm;
    int   addr;
    int   sum;
    bit   taken;
    exp_t e;
    imm   = opnd % (MASK + 1);
    addr  = opnd % RAM_DEPTH;
    taken = 0;
    case (op)
      OP_LIT:   begin m_acc = imm; m_z = (m_acc == 0); end
      OP_ADDI:  begin sum = m_acc + imm; m_c = (sum > MASK); m_acc = sum % (MASK + 1); m_z = (m_acc == 0); end
      OP_NANDI: begin m_acc = MASK - (m_acc & imm); m_z = (m_acc == 0); end
      OP_CMPI:  begin m_c = (m_acc >= imm); m_z = (m_acc == imm); end
      OP_LD:    begin m_acc = m_ram[addr]; m_z = (m_acc == 0); end
      OP_ST:    begin m_ram[addr] = m_acc; wr_q.push_back('{addr, m_acc}); end
      OP_ADDM:  begin sum = m_acc + m_ram[addr]; m_c = (sum > MASK); m_acc = sum % (MASK + 1); m_z = (m_acc == 0); end
      OP_IN:    begin m_acc = pb % (MASK + 1); m_z = (m_acc == 0); end
      OP_OUT:   m_out = m_acc;
      OP_JMP:   taken = 1;
      OP_JC:    taken = (m_c != 0);
      OP_JNC:   taken = (m_c == 0);
      OP_JZ:    taken = (m_z != 0);
      OP_JNZ:   taken = (m_z == 0);
      OP_HALT:  m_halt = 1;
      default:  ;
    endcase
    if (op != OP_HALT) m_pc = taken ? (opnd % PC_SPAN) : (m_pc + 1) % PC_SPAN;
    e = '{m_pc, m_acc, m_c, m_z, m_out, m_halt};
    exp_q.push_back(e);
  endtask

  // Presents one instruction after the requested number of stalled fetch cycles.
  task automatic applyStimulus(input logic [3:0] op, input int opnd, input int stalls, input int pb);
    logic [PW-1:0] opnd_v;
    opnd_v      = opnd[PW-1:0];
    pushbuttons = pb[W-1:0];
    for (int s = 0; s < stalls; s++) begin
      bus.instr_valid = 1'b0;
      bus.instr_word  = 16'($urandom);
      @(negedge clock);
      checkOutput("stall_phase", phase, 0);
      checkOutput("stall_pc", bus.pc, m_pc);
    end
    bus.instr_valid = 1'b1;
    bus.instr_word  = {op, opnd_v};
    model_exec(op, opnd, pb);
    @(negedge clock);
    bus.instr_valid = 1'b0;
    bus.instr_word  = 16'($urandom);
    @(negedge clock);
  endtask

  // Monitor: compares architectural state after every completed execute and every RAM write.
  always @(negedge clock or negedge reset) begin
    exp_t e;
    wr_t  w;
    if (!reset) begin
      prev_phase <= 1'b0;
    end else begin
      if (bus.ram_we) begin
        checkOutput("write_expected", wr_q.size() > 0, 1);
        if (wr_q.size() > 0) begin
          w = wr_q.pop_front();
          checkOutput("ram_addr", bus.ram_addr, w.addr);
          checkOutput("ram_wdata", bus.ram_wdata, w.data);
        end
      end
      if (prev_phase && !phase) begin
        checkOutput("completion_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          checkOutput("pc", bus.pc, e.pc);
          checkOutput("accu", accu, e.accu);
          checkOutput("c_flag", c_flag, e.c);
          checkOutput("z_flag", z_flag, e.z);
          checkOutput("ff_out", ff_out, e.ff_out);
          checkOutput("halted", halted, e.halted);
        end
      end
      prev_phase <= phase;
    end
  end

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_pc"}, bus.pc, 0);
    checkOutput({tag, "_phase"}, phase, 0);
    checkOutput({tag, "_accu"}, accu, 0);
    checkOutput({tag, "_ff_out"}, ff_out, 0);
    checkOutput({tag, "_c"}, c_flag, 0);
    checkOutput({tag, "_z"}, z_flag, 0);
    checkOutput({tag, "_halted"}, halted, 0);
    checkOutput({tag, "_ram_we"}, bus.ram_we, 0);
    checkOutput({tag, "_ram_addr"}, bus.ram_addr, 0);
  endtask

  initial begin
    int op;
    int opnd;
    checks          = 0;
    errors          = 0;
    reset           = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr_word  = '0;
    pushbuttons     = '0;
    for (int a = 0; a < RAM_DEPTH; a++) begin
      init_mem[a] = int'($urandom_range(0, MASK));
      m_ram[a]    = init_mem[a];
    end
    model_reset();

    @(negedge clock);
    check_reset_values("por");
    reset = 1'b1;

    // Reset in the middle of a store abandons it.
    applyStimulus(OP_LIT, 5, 0, 0);
    bus.instr_valid = 1'b1;
    bus.instr_word  = {OP_ST, 12'h007};
    wr_q.push_back('{7, 5});
    @(negedge clock);
    bus.instr_valid = 1'b0;
    checkOutput("st_we_in_exec", bus.ram_we, 1);
    #2 reset = 1'b0;
    #1 check_reset_values("mid_st");
    model_reset();
    @(negedge clock);
    checkOutput("st_no_write", env_written[7], 0);
    reset = 1'b1;

    // Add with carry out to zero, then nand keeps carry.
    applyStimulus(OP_LIT, 'hF, 0, 0);
    applyStimulus(OP_ADDI, 'h1, 0, 0);
    checkOutput("addi_accu", accu, 0);
    checkOutput("addi_c", c_flag, 1);
    checkOutput("addi_z", z_flag, 1);
    checkOutput("addi_pc", bus.pc, 2);
    applyStimulus(OP_NANDI, 'h3, 0, 0);
    checkOutput("nandi_accu", accu, 'hF);
    checkOutput("nandi_z", z_flag, 0);
    checkOutput("nandi_c", c_flag, 1);

    applyStimulus(OP_LIT, 6, 3, 0);
    checkOutput("stall_accu", accu, 6);
    checkOutput("stall_resume_pc", bus.pc, 4);

    // Input, output, store and reload through RAM.
    applyStimulus(OP_IN, 0, 0, 'b1010);
    applyStimulus(OP_OUT, 0, 0, 0);
    checkOutput("out_ff", ff_out, 'hA);
    applyStimulus(OP_ST, 'h005, 0, 0);
    checkOutput("st_env_ram", env_mem[5], 'hA);
    applyStimulus(OP_LIT, 0, 0, 0);
    applyStimulus(OP_LD, 'h005, 0, 0);
    checkOutput("ld_accu", accu, 'hA);

    // Compare and branch.
    applyStimulus(OP_LIT, 'hA, 0, 0);
    applyStimulus(OP_CMPI, 'hA, 0, 0);
    checkOutput("cmp_eq_z", z_flag, 1);
    checkOutput("cmp_eq_c", c_flag, 1);
    applyStimulus(OP_JZ, 'h123, 0, 0);
    checkOutput("jz_pc", bus.pc, 'h123);
    applyStimulus(OP_JNZ, 'h456, 0, 0);
    checkOutput("jnz_pc", bus.pc, 'h124);
    applyStimulus(OP_CMPI, 'hB, 0, 0);
    checkOutput("cmp_lt_c", c_flag, 0);
    checkOutput("cmp_lt_accu", accu, 'hA);

    applyStimulus(OP_JMP, 'hFFF, 0, 0);
    applyStimulus(OP_NOP, 0, 0, 0);
    checkOutput("pc_wrap", bus.pc, 0);

    for (int i = 0; i < 300; i++) begin
      op = int'($urandom_range(0, 14));
      if (op == OP_LD || op == OP_ST || op == OP_ADDM) opnd = int'($urandom_range(0, 15));
      else opnd = int'($urandom_range(0, PC_SPAN - 1));
      applyStimulus(op[3:0], opnd, int'($urandom_range(0, 2)), int'($urandom_range(0, MASK)));
    end

    // HALT freezes the core until reset.
    applyStimulus(OP_JMP, 'h010, 0, 0);
    applyStimulus(OP_HALT, 0, 0, 0);
    checkOutput("halt_flag", halted, 1);
    bus.instr_valid = 1'b1;
    bus.instr_word  = {OP_LIT, 12'h003};
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      checkOutput("halt_phase", phase, 0);
      checkOutput("halt_pc", bus.pc, 'h010);
    end
    bus.instr_valid = 1'b0;
    reset = 1'b0;
    #1 checkOutput("halt_cleared", halted, 0);
    checkOutput("halt_reset_pc", bus.pc, 0);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    checkOutput("scoreboard_drained", exp_q.size(), 0);
    checkOutput("writes_drained", wr_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
